// File: rtl/adder_tree_pkg.sv
// Shared constants and helpers for the pipelined signed adder tree.
//   MODE_*     : per-transaction output mode encodings
//   clog2      : ceiling log2 for parameter derivation
//   lvl_cnt    : number of partial sums left after a given number of tree levels
//   sat_to_n   : clamp a signed value (carried at 64 bits) to n-bit range, flag clamping
package adder_tree_pkg;

  localparam logic [1:0] MODE_WRAP  = 2'd0;
  localparam logic [1:0] MODE_SAT   = 2'd1;
  localparam logic [1:0] MODE_SCALE = 2'd2;
  localparam logic [1:0] MODE_RSVD  = 2'd3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int lvl_cnt(input int n, input int lvl);
    int c;
    c = n;
    for (int i = 0; i < lvl; i++) c = (c + 1) / 2;
    return c;
  endfunction

  // Callers pass the full-precision value sign-extended to 64 bits and keep
  // only the low n bits of the result.
  function automatic logic signed [63:0] sat_to_n(input logic signed [63:0] v,
                                                  input int n,
                                                  output logic ovf);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi  = (64'sd1 <<< (n - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (n - 1));
    ovf = (v > hi) || (v < lo);
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/adder_tree_stage.sv
// One registered level of the adder tree.
//   clk, rst        : clock, async active-high reset
//   en              : advance enable (global stall when low)
//   in_valid/mode   : valid bit and mode travelling with the data
//   in_data         : CNT_IN signed W-bit partial sums, element j at [j*W +: W]
//   out_valid/mode  : registered valid/mode
//   out_data        : CNT_OUT registered partial sums; an odd leftover passes through
module adder_tree_stage #(
  parameter int W       = 18,
  parameter int CNT_IN  = 4,
  parameter int CNT_OUT = (CNT_IN + 1) / 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic [1:0]           in_mode,
  input  logic [CNT_IN*W-1:0]  in_data,
  output logic                 out_valid,
  output logic [1:0]           out_mode,
  output logic [CNT_OUT*W-1:0] out_data
);

  logic [CNT_OUT*W-1:0] nxt;

  for (genvar j = 0; j < CNT_IN / 2; j++) begin : g_pair
    assign nxt[j*W +: W] = in_data[(2*j)*W +: W] + in_data[(2*j+1)*W +: W];
  end

  if (CNT_IN % 2 == 1) begin : g_odd
    assign nxt[(CNT_OUT-1)*W +: W] = in_data[(CNT_IN-1)*W +: W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_mode  <= '0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= in_valid;
      out_mode  <= in_mode;
      out_data  <= nxt;
    end
  end

endmodule

// File: rtl/adder_tree_pipe.sv
// Pipelined multi-operand signed adder with wrap / saturate / round+scale output.
//   clk, rst            : clock, async active-high reset
//   in_valid, in_ready  : input handshake
//   in_data             : NUM_IN signed N-bit operands, operand k at [k*N +: N]
//   in_mode             : 0 wrap, 1 saturate, 2 round+scale, 3 treated as wrap
//   out_valid, out_ready: output handshake
//   out_data, out_ovf   : signed result and "did not fit in N bits" flag
module adder_tree_pipe
  import adder_tree_pkg::*;
#(
  parameter int N      = 16,
  parameter int NUM_IN = 4,
  parameter int SHIFT  = clog2(NUM_IN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NUM_IN*N-1:0] in_data,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_data,
  output logic              out_ovf
);

  localparam int LEVELS = clog2(NUM_IN);
  localparam int SW     = N + LEVELS;
  // Half-LSB rounding constant; zero when no shift is applied.
  localparam logic signed [SW:0] RND = (SW+1)'((2 ** SHIFT) / 2);

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic [NUM_IN*SW-1:0] ext;
  for (genvar k = 0; k < NUM_IN; k++) begin : g_ext
    assign ext[k*SW +: SW] = {{LEVELS{in_data[k*N+N-1]}}, in_data[k*N +: N]};
  end

  for (genvar i = 0; i < LEVELS; i++) begin : g_lvl
    localparam int CI = lvl_cnt(NUM_IN, i);
    localparam int CO = lvl_cnt(NUM_IN, i + 1);
    logic [CI*SW-1:0] d_in;
    logic             v_in;
    logic [1:0]       m_in;
    logic [CO*SW-1:0] d_out;
    logic             v_out;
    logic [1:0]       m_out;

    if (i == 0) begin : g_src
      assign d_in = ext;
      assign v_in = in_valid;
      assign m_in = in_mode;
    end else begin : g_chain
      assign d_in = g_lvl[i-1].d_out;
      assign v_in = g_lvl[i-1].v_out;
      assign m_in = g_lvl[i-1].m_out;
    end

    adder_tree_stage #(.W(SW), .CNT_IN(CI), .CNT_OUT(CO)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .en       (adv),
      .in_valid (v_in),
      .in_mode  (m_in),
      .in_data  (d_in),
      .out_valid(v_out),
      .out_mode (m_out),
      .out_data (d_out)
    );
  end

  logic signed [SW-1:0] sum;
  logic                 sum_valid;
  logic [1:0]           sum_mode;
  assign sum       = g_lvl[LEVELS-1].d_out;
  assign sum_valid = g_lvl[LEVELS-1].v_out;
  assign sum_mode  = g_lvl[LEVELS-1].m_out;

  logic signed [63:0] sum64;
  logic signed [SW:0] rnd;
  logic signed [SW:0] scaled;
  logic signed [63:0] scaled64;
  logic [N-1:0]       sat_val;
  logic [N-1:0]       scl_val;
  logic               sat_ovf;
  logic               scl_ovf;
  logic [N-1:0]       res_data;
  logic               res_ovf;

  always_comb begin
    sum64    = {{(64-SW){sum[SW-1]}}, sum};
    // One extra bit of headroom so the rounding add cannot wrap.
    rnd      = {sum[SW-1], sum} + RND;
    scaled   = rnd >>> SHIFT;
    scaled64 = {{(63-SW){scaled[SW]}}, scaled};
    sat_ovf  = 1'b0;
    scl_ovf  = 1'b0;
    sat_val  = N'(sat_to_n(sum64, N, sat_ovf));
    scl_val  = N'(sat_to_n(scaled64, N, scl_ovf));
    res_data = sum[N-1:0];
    res_ovf  = sat_ovf;
    case (sum_mode)
      MODE_SAT: begin
        res_data = sat_val;
        res_ovf  = sat_ovf;
      end
      MODE_SCALE: begin
        res_data = scl_val;
        res_ovf  = scl_ovf;
      end
      MODE_WRAP, MODE_RSVD: begin
        res_data = sum[N-1:0];
        res_ovf  = sat_ovf;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else if (adv) begin
      out_valid <= sum_valid;
      if (sum_valid) begin
        out_data <= res_data;
        out_ovf  <= res_ovf;
      end
    end
  end

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Scoreboard bench for adder_tree_pipe: a 4-input instance (a_*) and a 3-input
// instance (b_*), both N=16, SHIFT=2, latency 3.
module tb_adder_tree_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned cyc_cnt = 0;
  always @(posedge clk) cyc_cnt++;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf;
  logic [63:0] a_in_data;
  logic [1:0]  a_in_mode;
  logic [15:0] a_out_data;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf;
  logic [47:0] b_in_data;
  logic [1:0]  b_in_mode;
  logic [15:0] b_out_data;

  adder_tree_pipe #(.N(16), .NUM_IN(4), .SHIFT(2)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_mode(a_in_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_ovf(a_out_ovf)
  );

  adder_tree_pipe #(.N(16), .NUM_IN(3), .SHIFT(2)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_ovf(b_out_ovf)
  );

  typedef struct {
    logic [15:0] data;
    logic        ovf;
    int unsigned cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int n_chk  = 0;
  int n_fail = 0;
  bit lat_chk = 1'b1;
  bit acc_a = 1'b0;
  int out_cnt_a = 0;
  bit stall_a = 1'b0, stall_b = 1'b0;
  logic [15:0] hold_a, hold_b;
  logic        hold_ovf_a, hold_ovf_b;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: exact integer sum, then the selected output mode.
  function automatic void model(input logic [63:0] d, input int cnt, input logic [1:0] m,
                                output logic [15:0] r, output logic o);
    int s, t, c;
    logic signed [15:0] op;
    s = 0;
    for (int k = 0; k < cnt; k++) begin
      op = d[k*16 +: 16];
      s += op;
    end
    t = (m == 2'd2) ? ((s + 2) >>> 2) : s;
    c = (t > 32767) ? 32767 : ((t < -32768) ? -32768 : t);
    if (m == 2'd1 || m == 2'd2) begin
      r = c[15:0];
      o = (t > 32767) || (t < -32768);
    end else begin
      r = s[15:0];
      o = (s > 32767) || (s < -32768);
    end
  endfunction

  task automatic monitor();
    exp_t e;
    acc_a = 1'b0;
    if (a_in_valid && a_in_ready) begin
      model(a_in_data, 4, a_in_mode, e.data, e.ovf);
      e.cyc = cyc_cnt;
      qa.push_back(e);
      acc_a = 1'b1;
    end
    if (b_in_valid && b_in_ready) begin
      model({16'h0, b_in_data}, 3, b_in_mode, e.data, e.ovf);
      e.cyc = cyc_cnt;
      qb.push_back(e);
    end
    chk("a_in_ready", a_in_ready, !a_out_valid || a_out_ready);
    if (stall_a) begin
      chk("a_stall_valid", a_out_valid, 1);
      chk("a_stall_data", a_out_data, hold_a);
      chk("a_stall_ovf", a_out_ovf, hold_ovf_a);
    end
    if (stall_b) begin
      chk("b_stall_valid", b_out_valid, 1);
      chk("b_stall_data", b_out_data, hold_b);
    end
    if (a_out_valid && a_out_ready) begin
      out_cnt_a++;
      if (qa.size() == 0) chk("a_spurious", a_out_valid, 0);
      else begin
        e = qa.pop_front();
        chk("a_data", a_out_data, e.data);
        chk("a_ovf", a_out_ovf, e.ovf);
        if (lat_chk) chk("a_latency", cyc_cnt - e.cyc, 3);
      end
    end
    if (b_out_valid && b_out_ready) begin
      if (qb.size() == 0) chk("b_spurious", b_out_valid, 0);
      else begin
        e = qb.pop_front();
        chk("b_data", b_out_data, e.data);
        chk("b_ovf", b_out_ovf, e.ovf);
        if (lat_chk) chk("b_latency", cyc_cnt - e.cyc, 3);
      end
    end
    stall_a    = a_out_valid && !a_out_ready;
    stall_b    = b_out_valid && !b_out_ready;
    hold_a     = a_out_data;
    hold_ovf_a = a_out_ovf;
    hold_b     = b_out_data;
  endtask

  task automatic cyc_a(input logic v, input logic [63:0] d, input logic [1:0] m, input logic r);
    @(negedge clk);
    a_in_valid = v; a_in_data = d; a_in_mode = m; a_out_ready = r;
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    #1 monitor();
  endtask

  task automatic cyc_b(input logic v, input logic [47:0] d, input logic [1:0] m);
    @(negedge clk);
    b_in_valid = v; b_in_data = d; b_in_mode = m; b_out_ready = 1'b1;
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    #1 monitor();
  endtask

  initial begin
    int sent, guard, base_cnt;
    logic [63:0] vec;
    logic [1:0]  md;

    rst = 1'b1;
    a_in_valid = 0; a_in_data = '0; a_in_mode = '0; a_out_ready = 1;
    b_in_valid = 0; b_in_data = '0; b_in_mode = '0; b_out_ready = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_a_valid", a_out_valid, 0);
    chk("rst_a_data", a_out_data, 0);
    chk("rst_a_ovf", a_out_ovf, 0);
    chk("rst_b_valid", b_out_valid, 0);
    @(negedge clk);
    rst = 1'b0;

    // wrap, overflow, scale
    lat_chk = 1'b1;
    cyc_a(1, {16'd4, 16'd3, 16'd2, 16'd1}, 2'd0, 1);
    cyc_a(1, {4{16'h7000}}, 2'd1, 1);
    cyc_a(1, {4{16'h7000}}, 2'd0, 1);
    cyc_a(1, {4{16'h7000}}, 2'd2, 1);
    cyc_a(1, {16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 2'd2, 1);
    cyc_a(1, {4{16'h8000}}, 2'd3, 1);
    cyc_a(1, {4{16'h8000}}, 2'd1, 1);
    repeat (6) cyc_a(0, '0, 2'd0, 1);

    // back-to-back under random backpressure
    lat_chk  = 1'b0;
    base_cnt = out_cnt_a;
    sent = 0; guard = 0;
    vec = {$urandom, $urandom};
    md  = 2'($urandom_range(0, 3));
    while (sent < 16 && guard < 400) begin
      cyc_a(1, vec, md, 1'($urandom_range(0, 1)));
      if (acc_a) begin
        sent++;
        vec = {$urandom, $urandom};
        md  = 2'($urandom_range(0, 3));
      end
      guard++;
    end
    chk("bp_all_sent", sent, 16);
    guard = 0;
    while (qa.size() != 0 && guard < 200) begin
      cyc_a(0, '0, 2'd0, 1'($urandom_range(0, 1)));
      guard++;
    end
    chk("bp_result_count", out_cnt_a - base_cnt, 16);

    // reset with three transactions in flight
    lat_chk = 1'b1;
    cyc_a(1, {4{16'h0011}}, 2'd0, 1);
    cyc_a(1, {4{16'h0022}}, 2'd1, 1);
    cyc_a(1, {4{16'h0033}}, 2'd2, 1);
    @(negedge clk);
    rst = 1'b1;
    a_in_valid = 1'b0;
    #1;
    chk("rst_mid_a_valid", a_out_valid, 0);
    chk("rst_mid_b_valid", b_out_valid, 0);
    qa.delete();
    qb.delete();
    stall_a = 1'b0;
    stall_b = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cyc_a(1, {16'd40, 16'd30, 16'd20, 16'd10}, 2'd0, 1);
    repeat (6) cyc_a(0, '0, 2'd0, 1);

    // three-operand instance, per-transaction modes
    cyc_b(1, {3{16'h8000}}, 2'd1);
    cyc_b(1, {3{16'h7000}}, 2'd0);
    cyc_b(1, {3{16'h7000}}, 2'd1);
    cyc_b(1, {3{16'h7000}}, 2'd2);
    cyc_b(1, {16'd5, 16'hFFFE, 16'd1}, 2'd2);
    repeat (6) cyc_b(0, '0, 2'd0);

    guard = 0;
    while ((qa.size() != 0 || qb.size() != 0) && guard < 50) begin
      cyc_a(0, '0, 2'd0, 1);
      guard++;
    end
    chk("drain_a", qa.size(), 0);
    chk("drain_b", qb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
